pipeline_hazard_ctrl: RTL and testbench

//  Hazard and sequencing controller for the 5-stage MIPS pipeline. It drives the
//  PC, IF/ID, ID/EX and EX/MEM enables and flushes to handle three cases:
//  - load-use hazards: one bubble.
//  - taken branch/jump resolved in EX: squash the two younger stages.
//  - multi-cycle multiply: hold EX for MUL_LATENCY cycles.

---
 rtl/pipeline_hazard_ctrl.sv | 166 ++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage MIPS pipeline: load-use bubble,
// taken-branch squash and multi-cycle mul hold. Optional perf counters: HAZ_PERF_CNT_EN.
module pipeline_hazard_ctrl #(
    parameter int MUL_LATENCY = 4,
    parameter int CNT_W       = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rt,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rt,
    input  logic        ex_mul_op,
    input  logic        ex_br_taken,
    output logic        pc_write,
    output logic        if_id_write,
    output logic        if_id_flush,
    output logic        id_ex_write,
    output logic        id_ex_flush,
    output logic        ex_mem_bubble,
    output logic        busy,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
);

    typedef enum logic [0:0] {S_RUN = 1'b0, S_MUL_BUSY = 1'b1} state_t;

    localparam bit             MUL_STALLS = (MUL_LATENCY > 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_LATENCY > 1 ? MUL_LATENCY - 2 : 0);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             w_load_use;
    logic             w_br_squash;
    logic             w_mul_start;
    logic             w_pc_write;
    logic             w_if_id_write;
    logic             w_if_id_flush;
    logic             w_id_ex_write;
    logic             w_id_ex_flush;
    logic             w_ex_mem_bubble;

    // Hazard detection and pipeline control decode from state and live inputs
    always_comb begin
        w_load_use  = ex_mem_read && (ex_rt != 5'd0) &&
                      ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
        w_br_squash = rst_n && (r_state == S_RUN) && ex_br_taken;
        w_mul_start = rst_n && (r_state == S_RUN) && !ex_br_taken && ex_mul_op && MUL_STALLS;

        w_pc_write      = 1'b1;
        w_if_id_write   = 1'b1;
        w_if_id_flush   = 1'b0;
        w_id_ex_write   = 1'b1;
        w_id_ex_flush   = 1'b0;
        w_ex_mem_bubble = 1'b0;

        // Held reset drains the pipe: front end frozen, every stage cleared
        if (!rst_n) begin
            w_pc_write      = 1'b0;
            w_if_id_write   = 1'b0;
            w_if_id_flush   = 1'b1;
            w_id_ex_flush   = 1'b1;
            w_ex_mem_bubble = 1'b1;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (w_br_squash) begin
                        w_if_id_flush = 1'b1;
                        w_id_ex_flush = 1'b1;
                    end else if (w_mul_start) begin
                        w_pc_write      = 1'b0;
                        w_if_id_write   = 1'b0;
                        w_id_ex_write   = 1'b0;
                        w_ex_mem_bubble = 1'b1;
                    end else if (w_load_use) begin
                        w_pc_write    = 1'b0;
                        w_if_id_write = 1'b0;
                        w_id_ex_flush = 1'b1;
                    end else begin
                        w_pc_write = 1'b1;
                    end
                end
                S_MUL_BUSY: begin
                    if (r_cnt != {CNT_W{1'b0}}) begin
                        w_pc_write      = 1'b0;
                        w_if_id_write   = 1'b0;
                        w_id_ex_write   = 1'b0;
                        w_ex_mem_bubble = 1'b1;
                    end else begin
                        w_pc_write = 1'b1;
                    end
                end
                default: begin
                    w_pc_write = 1'b1;
                end
            endcase
        end
    end

    assign pc_write      = w_pc_write;
    assign if_id_write   = w_if_id_write;
    assign if_id_flush   = w_if_id_flush;
    assign id_ex_write   = w_id_ex_write;
    assign id_ex_flush   = w_id_ex_flush;
    assign ex_mem_bubble = w_ex_mem_bubble;
    assign busy          = (r_state == S_MUL_BUSY);

    // Mul sequencing FSM; the RUN cycle that sees the mul is the first stall cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_RUN;
            r_cnt   <= {CNT_W{1'b0}};
        end else begin
            case (r_state)
                S_RUN: begin
                    if (w_mul_start) begin
                        r_state <= S_MUL_BUSY;
                        r_cnt   <= CNT_LOAD;
                    end else begin
                        r_state <= S_RUN;
                        r_cnt   <= {CNT_W{1'b0}};
                    end
                end
                S_MUL_BUSY: begin
                    if (r_cnt != {CNT_W{1'b0}}) begin
                        r_cnt <= r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
                    end else begin
                        r_state <= S_RUN;
                    end
                end
                default: begin
                    r_state <= S_RUN;
                    r_cnt   <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    // Performance counters: front-end stall cycles and branch squashes, wrapping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= 32'd0;
            r_flush_cnt <= 32'd0;
        end else begin
            if (!w_pc_write) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (w_br_squash) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`else
    assign stall_cnt = 32'd0;
    assign flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed table-driven bench for pipeline_hazard_ctrl (MUL_LATENCY=4).
module tb_pipeline_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  id_rs, id_rt, ex_rt;
    logic        id_uses_rt, ex_mem_read, ex_mul_op, ex_br_taken;
    logic        pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush;
    logic        ex_mem_bubble, busy;
    logic [31:0] stall_cnt, flush_cnt;

`ifdef HAZ_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    pipeline_hazard_ctrl #(.MUL_LATENCY(4), .CNT_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .ex_mul_op(ex_mul_op), .ex_br_taken(ex_br_taken),
        .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
        .id_ex_write(id_ex_write), .id_ex_flush(id_ex_flush), .ex_mem_bubble(ex_mem_bubble),
        .busy(busy), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    // expected outputs packed as {pc_w, ifid_w, ifid_f, idex_w, idex_f, bubble, busy}
    typedef struct {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses_rt;
        logic       mem_read;
        logic [4:0] exrt;
        logic       mul;
        logic       br;
        logic [6:0] exp;
    } vec_t;

    localparam logic [6:0] O_RUN  = 7'b1101000;
    localparam logic [6:0] O_LU   = 7'b0001100;
    localparam logic [6:0] O_BR   = 7'b1111100;
    localparam logic [6:0] O_MUL0 = 7'b0000010;
    localparam logic [6:0] O_MULB = 7'b0000011;
    localparam logic [6:0] O_REL  = 7'b1101001;
    localparam logic [6:0] O_RST  = 7'b0011110;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] exp_stall = 32'd0;
    logic [31:0] exp_flush = 32'd0;
    vec_t tbl[9];

    function automatic vec_t mkv(input logic [4:0] rs, input logic [4:0] rt, input logic uses,
                                 input logic rd, input logic [4:0] exrt, input logic mul,
                                 input logic br, input logic [6:0] exp);
        vec_t v;
        v.rs = rs; v.rt = rt; v.uses_rt = uses; v.mem_read = rd;
        v.exrt = exrt; v.mul = mul; v.br = br; v.exp = exp;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [6:0] outs();
        return {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush, ex_mem_bubble, busy};
    endfunction

    // drive one cycle, compare at negedge, then account counters for the completed cycle
    task automatic step(input vec_t v, input string nm);
        id_rs = v.rs; id_rt = v.rt; id_uses_rt = v.uses_rt; ex_mem_read = v.mem_read;
        ex_rt = v.exrt; ex_mul_op = v.mul; ex_br_taken = v.br;
        @(negedge clk);
        check({nm, ".outs"}, {25'd0, outs()}, {25'd0, v.exp});
        check({nm, ".stall_cnt"}, stall_cnt, PERF ? exp_stall : 32'd0);
        check({nm, ".flush_cnt"}, flush_cnt, PERF ? exp_flush : 32'd0);
        if (v.exp[6] == 1'b0) exp_stall = exp_stall + 32'd1;
        if (v.exp[4] == 1'b1 && v.exp[6] == 1'b1) exp_flush = exp_flush + 32'd1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        tbl[0] = mkv(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, O_RUN);
        tbl[1] = mkv(5'd8, 5'd2, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, O_LU);
        tbl[2] = mkv(5'd8, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, O_RUN);
        tbl[3] = mkv(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, O_RUN);
        tbl[4] = mkv(5'd3, 5'd9, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, O_RUN);
        tbl[5] = mkv(5'd3, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, O_LU);
        tbl[6] = mkv(5'd9, 5'd9, 1'b1, 1'b0, 5'd9, 1'b0, 1'b0, O_RUN);
        tbl[7] = mkv(5'd8, 5'd2, 1'b0, 1'b1, 5'd8, 1'b0, 1'b1, O_BR);
        tbl[8] = mkv(5'd1, 5'd2, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1, O_BR);

        rst_n = 1'b0; id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0;
        ex_mem_read = 1'b0; ex_rt = 5'd0; ex_mul_op = 1'b0; ex_br_taken = 1'b0;
        @(negedge clk);
        check("reset.outs", {25'd0, outs()}, {25'd0, O_RST});
        check("reset.stall_cnt", stall_cnt, 32'd0);
        check("reset.flush_cnt", flush_cnt, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) step(tbl[i], $sformatf("tbl%0d", i));

        // mul held in EX; a branch during MUL_BUSY is ignored; second mul back-to-back
        step(mkv(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, O_MUL0), "mul1.c1");
        step(mkv(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, O_MULB), "mul1.c2");
        step(mkv(5'd4, 5'd0, 1'b0, 1'b1, 5'd4, 1'b1, 1'b1, O_MULB), "mul1.c3");
        step(mkv(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, O_REL),  "mul1.rel");
        step(mkv(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, O_MUL0), "mul2.c1");
        step(mkv(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, O_MULB), "mul2.c2");
        step(mkv(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, O_MULB), "mul2.c3");
        step(mkv(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, O_REL),  "mul2.rel");
        step(mkv(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, O_RUN),  "mul2.after");

        // reset asserted on the second MUL_BUSY cycle aborts at once
        step(mkv(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, O_MUL0), "rmul.c1");
        step(mkv(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, O_MULB), "rmul.c2");
        rst_n = 1'b0;
        #1;
        check("rmul.abort", {25'd0, outs()}, {25'd0, O_RST});
        check("rmul.stall_cnt", stall_cnt, 32'd0);
        check("rmul.flush_cnt", flush_cnt, 32'd0);
        exp_stall = 32'd0;
        exp_flush = 32'd0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        step(mkv(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, O_RUN), "rmul.clean");

        // perf scenario: one load-use stall plus one 4-cycle mul gives 4 stall cycles
        step(mkv(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, O_LU),   "perf.lu");
        step(mkv(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, O_MUL0), "perf.m1");
        step(mkv(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, O_MULB), "perf.m2");
        step(mkv(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, O_MULB), "perf.m3");
        step(mkv(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, O_REL),  "perf.rel");
        step(mkv(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, O_BR),   "perf.br");
        @(negedge clk);
        check("perf.stall4", stall_cnt, PERF ? 32'd4 : 32'd0);
        check("perf.flush1", flush_cnt, PERF ? 32'd1 : 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
